// File: rtl/pc_context_scheduler.sv
// Program counter with a built-in preemptive round-robin scheduler.
//
// Sits between the next-PC mux and the instruction ROM address port. While the OS
// runs, pc_out follows next_addr and the OS may launch processes into context
// slots and dispatch the next ready one. While a user process runs, pc_out follows
// next_addr until the process ends or its time slice of QUANTUM instructions runs
// out. Either way control returns to the OS at the address recorded on dispatch.
//
// Ports:
//   CLK, reset        rising-edge clock, asynchronous active-high reset
//   stall             freezes all state (ctx_switch reads 0 while stalled)
//   next_addr         next PC from the fetch/branch logic
//   end_process       running process executed its terminating instruction
//   launch/launch_pid/launch_addr   OS loads a start PC into a slot and marks it alive
//   dispatch          OS request to run the next ready process
//   rd_pid / rd_pc    combinational debug read of a saved PC
//   pc_out            current instruction address
//   os_mode           1 = OS code running, 0 = user process running
//   cur_pid           running or last-run process id
//   ctx_switch        one-cycle pulse after each return to the OS
//   active            per-slot "process alive" mask
module pc_context_scheduler #(
  parameter int unsigned      ADDR_W     = 32,
  parameter int unsigned      NPROC      = 4,
  parameter int unsigned      PID_W      = 2,
  parameter int unsigned      QUANTUM    = 42,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              stall,
  input  logic [ADDR_W-1:0] next_addr,
  input  logic              end_process,
  input  logic              launch,
  input  logic [PID_W-1:0]  launch_pid,
  input  logic [ADDR_W-1:0] launch_addr,
  input  logic              dispatch,
  input  logic [PID_W-1:0]  rd_pid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              os_mode,
  output logic [PID_W-1:0]  cur_pid,
  output logic              ctx_switch,
  output logic [NPROC-1:0]  active,
  output logic [ADDR_W-1:0] rd_pc
);

  localparam int unsigned CNT_W = $clog2(QUANTUM + 1);
  localparam int unsigned IDX_W = $clog2(NPROC);

  typedef enum logic {StOs, StRun} stateT;

  stateT             stateQ, stateD;
  logic [ADDR_W-1:0] pcQ, pcD;
  logic [PID_W-1:0]  curPidQ, curPidD;
  logic              ctxSwitchQ, ctxSwitchD;
  logic [NPROC-1:0]  activeQ, activeD;
  logic [CNT_W-1:0]  cntQ, cntD;
  logic [ADDR_W-1:0] osReturnQ, osReturnD;
  logic [ADDR_W-1:0] savedQ [NPROC];
  logic [ADDR_W-1:0] savedD [NPROC];

  logic              found;
  logic [IDX_W-1:0]  selIdx;
  logic [IDX_W-1:0]  candIdx;
  logic [ADDR_W-1:0] selPc;
  int                candSum;

  always_comb begin
    stateD     = stateQ;
    pcD        = pcQ;
    curPidD    = curPidQ;
    ctxSwitchD = 1'b0;
    activeD    = activeQ;
    cntD       = cntQ;
    osReturnD  = osReturnQ;
    savedD     = savedQ;
    found      = 1'b0;
    selIdx     = '0;
    candIdx    = '0;
    selPc      = '0;
    candSum    = 0;

    if (!stall) begin
      unique case (stateQ)
        StOs: begin
          pcD = next_addr;
          // Launch is folded into the next-state view first so that a slot
          // launched this cycle is visible to a simultaneous dispatch.
          if (launch) begin
            for (int j = 0; j < int'(NPROC); j++) begin
              if (launch_pid == PID_W'(j)) begin
                savedD[j]  = launch_addr;
                activeD[j] = 1'b1;
              end
            end
          end
          if (dispatch) begin
            // Round-robin: cur_pid+1 .. cur_pid+NPROC (the last being cur_pid itself).
            for (int k = 1; k <= int'(NPROC); k++) begin
              candSum = int'(curPidQ) + k;
              if (candSum >= int'(NPROC)) begin
                candSum = candSum - int'(NPROC);
              end
              candIdx = IDX_W'(candSum);
              if (!found && activeD[candIdx]) begin
                found  = 1'b1;
                selIdx = candIdx;
              end
            end
            if (found) begin
              for (int j = 0; j < int'(NPROC); j++) begin
                if (selIdx == IDX_W'(j)) begin
                  selPc = savedD[j];
                end
              end
              osReturnD = next_addr;
              pcD       = selPc;
              curPidD   = PID_W'(selIdx);
              cntD      = '0;
              stateD    = StRun;
            end
          end
        end

        StRun: begin
          if (end_process) begin
            // Slot dies; its saved PC is left as-is.
            for (int j = 0; j < int'(NPROC); j++) begin
              if (curPidQ == PID_W'(j)) begin
                activeD[j] = 1'b0;
              end
            end
            pcD        = osReturnQ;
            ctxSwitchD = 1'b1;
            stateD     = StOs;
          end else if (cntQ == CNT_W'(QUANTUM - 1)) begin
            // The QUANTUM-th instruction is in flight: resume at what would follow it.
            for (int j = 0; j < int'(NPROC); j++) begin
              if (curPidQ == PID_W'(j)) begin
                savedD[j] = next_addr;
              end
            end
            pcD        = osReturnQ;
            ctxSwitchD = 1'b1;
            stateD     = StOs;
          end else begin
            pcD  = next_addr;
            cntD = cntQ + CNT_W'(1);
          end
        end

        default: stateD = StOs;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      stateQ     <= StOs;
      pcQ        <= RESET_ADDR;
      curPidQ    <= '0;
      ctxSwitchQ <= 1'b0;
      activeQ    <= '0;
      cntQ       <= '0;
      osReturnQ  <= RESET_ADDR;
      for (int j = 0; j < int'(NPROC); j++) begin
        savedQ[j] <= '0;
      end
    end else begin
      stateQ     <= stateD;
      pcQ        <= pcD;
      curPidQ    <= curPidD;
      ctxSwitchQ <= ctxSwitchD;
      activeQ    <= activeD;
      cntQ       <= cntD;
      osReturnQ  <= osReturnD;
      savedQ     <= savedD;
    end
  end

  always_comb begin
    rd_pc = '0;
    for (int j = 0; j < int'(NPROC); j++) begin
      if (rd_pid == PID_W'(j)) begin
        rd_pc = savedQ[j];
      end
    end
  end

  assign pc_out     = pcQ;
  assign os_mode    = (stateQ == StOs);
  assign cur_pid    = curPidQ;
  assign ctx_switch = ctxSwitchQ;
  assign active     = activeQ;

endmodule

// File: tb/tb_pc_context_scheduler.sv
module tb_pc_context_scheduler;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned NPROC   = 4;
  localparam int unsigned PID_W   = 2;
  localparam int unsigned QUANTUM = 42;

  logic              CLK;
  logic              reset;
  logic              stall;
  logic [ADDR_W-1:0] next_addr;
  logic              end_process;
  logic              launch;
  logic [PID_W-1:0]  launch_pid;
  logic [ADDR_W-1:0] launch_addr;
  logic              dispatch;
  logic [PID_W-1:0]  rd_pid;
  logic [ADDR_W-1:0] pc_out;
  logic              os_mode;
  logic [PID_W-1:0]  cur_pid;
  logic              ctx_switch;
  logic [NPROC-1:0]  active;
  logic [ADDR_W-1:0] rd_pc;

  pc_context_scheduler #(
    .ADDR_W    (ADDR_W),
    .NPROC     (NPROC),
    .PID_W     (PID_W),
    .QUANTUM   (QUANTUM),
    .RESET_ADDR('0)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .stall      (stall),
    .next_addr  (next_addr),
    .end_process(end_process),
    .launch     (launch),
    .launch_pid (launch_pid),
    .launch_addr(launch_addr),
    .dispatch   (dispatch),
    .rd_pid     (rd_pid),
    .pc_out     (pc_out),
    .os_mode    (os_mode),
    .cur_pid    (cur_pid),
    .ctx_switch (ctx_switch),
    .active     (active),
    .rd_pc      (rd_pc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int nCompared = 0;
  int nFailed   = 0;

  // Reference model: process table plus "instructions executed this slice".
  logic [31:0] mPc;
  logic [31:0] mOsRet;
  bit          mOs;
  bit          mCtx;
  int          mCur;
  int          mUsed;
  bit          mAlive [NPROC];
  logic [31:0] mSaved [NPROC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFailed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    mPc = 0; mOsRet = 0; mOs = 1; mCtx = 0; mCur = 0; mUsed = 0;
    for (int i = 0; i < int'(NPROC); i++) begin
      mAlive[i] = 0;
      mSaved[i] = 0;
    end
  endfunction

  function automatic logic [31:0] aliveMask();
    logic [31:0] m = 0;
    for (int i = 0; i < int'(NPROC); i++) m[i] = mAlive[i];
    return m;
  endfunction

  function automatic void modelTick();
    int pick = -1;
    if (stall) begin
      mCtx = 0;
      return;
    end
    mCtx = 0;
    if (mOs) begin
      mPc = next_addr;
      if (launch && int'(launch_pid) < int'(NPROC)) begin
        mSaved[launch_pid] = launch_addr;
        mAlive[launch_pid] = 1;
      end
      if (dispatch) begin
        for (int k = 1; k <= int'(NPROC); k++) begin
          if (pick < 0 && mAlive[(mCur + k) % int'(NPROC)]) pick = (mCur + k) % int'(NPROC);
        end
        if (pick >= 0) begin
          mOsRet = next_addr;
          mPc    = mSaved[pick];
          mCur   = pick;
          mUsed  = 0;
          mOs    = 0;
        end
      end
    end else begin
      mUsed++;
      if (end_process) begin
        mAlive[mCur] = 0;
        mPc = mOsRet; mCtx = 1; mOs = 1;
      end else if (mUsed == int'(QUANTUM)) begin
        mSaved[mCur] = next_addr;
        mPc = mOsRet; mCtx = 1; mOs = 1;
      end else begin
        mPc = next_addr;
      end
    end
  endfunction

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    chk("pc_out", pc_out, mPc);
    chk("os_mode", 32'(os_mode), 32'(mOs));
    chk("cur_pid", 32'(cur_pid), 32'(mCur));
    chk("ctx_switch", 32'(ctx_switch), 32'(mCtx));
    chk("active", 32'(active), aliveMask());
    chk("rd_pc", rd_pc, mSaved[rd_pid]);
  end

  task automatic tick();
    @(posedge CLK);
    if (!reset) modelTick();
    #2;
    launch      = 1'b0;
    dispatch    = 1'b0;
    end_process = 1'b0;
  endtask

  task automatic runSlice(input int n, input logic [31:0] base, input bit injectLaunch);
    for (int i = 1; i <= n; i++) begin
      next_addr = base + 32'(4 * i);
      if (injectLaunch && i == 3) begin
        launch = 1'b1; launch_pid = 2'd3; launch_addr = 32'hDEAD;
      end
      tick();
    end
  endtask

  task automatic doDispatch(input logic [31:0] na);
    next_addr = na;
    dispatch  = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; stall = 1'b0; next_addr = '0; end_process = 1'b0;
    launch = 1'b0; launch_pid = '0; launch_addr = '0; dispatch = 1'b0; rd_pid = 2'd1;
    modelReset();
    #1 reset = 1'b1;
    #1;
    chk("reset pc_out", pc_out, 32'h0);
    chk("reset os_mode", 32'(os_mode), 32'h1);
    chk("reset active", 32'(active), 32'h0);
    @(posedge CLK);
    #2 reset = 1'b0;

    // OS sequencing.
    for (int i = 1; i <= 5; i++) begin
      next_addr = 32'(4 * i);
      tick();
    end
    chk("os follow pc", pc_out, 32'd20);

    // First slice of slot 1.
    next_addr = 32'h24; launch = 1'b1; launch_pid = 2'd1; launch_addr = 32'h100;
    tick();
    doDispatch(32'h40);
    chk("dispatch pc", pc_out, 32'h100);
    chk("dispatch os_mode", 32'(os_mode), 32'h0);
    chk("dispatch cur_pid", 32'(cur_pid), 32'h1);
    runSlice(41, 32'h100, 1'b0);
    chk("slice 41 still running", 32'(os_mode), 32'h0);
    next_addr = 32'h1A8;
    tick();
    chk("expiry pc", pc_out, 32'h40);
    chk("expiry ctx_switch", 32'(ctx_switch), 32'h1);
    chk("expiry rd_pc", rd_pc, 32'h1A8);
    next_addr = 32'h44;
    tick();
    chk("ctx pulse width", 32'(ctx_switch), 32'h0);

    // Single active slot reselects itself, then ends.
    doDispatch(32'h48);
    chk("reselect pc", pc_out, 32'h1A8);
    next_addr = 32'h1AC; end_process = 1'b1;
    tick();
    chk("end os_mode", 32'(os_mode), 32'h1);
    chk("end pc", pc_out, 32'h48);
    chk("end rd_pc kept", rd_pc, 32'h1A8);
    doDispatch(32'h50);
    chk("empty dispatch ignored", 32'(os_mode), 32'h1);
    chk("empty dispatch pc", pc_out, 32'h50);

    // Launch + dispatch in one cycle; launch in RUN ignored.
    next_addr = 32'h54; launch = 1'b1; launch_pid = 2'd0; launch_addr = 32'h200; dispatch = 1'b1;
    tick();
    chk("launch+dispatch cur", 32'(cur_pid), 32'h0);
    chk("launch+dispatch pc", pc_out, 32'h200);
    runSlice(42, 32'h200, 1'b1);
    next_addr = 32'h58; launch = 1'b1; launch_pid = 2'd2; launch_addr = 32'h300;
    tick();
    next_addr = 32'h5C; launch = 1'b1; launch_pid = 2'd3; launch_addr = 32'h400;
    tick();
    chk("mask 0,2,3", 32'(active), 32'hD);

    // Round robin 2, 3, 0, 2.
    doDispatch(32'h60);
    chk("rr 2", 32'(cur_pid), 32'h2);
    chk("rr 2 pc", pc_out, 32'h300);
    runSlice(42, 32'h300, 1'b0);
    doDispatch(32'h64);
    chk("rr 3", 32'(cur_pid), 32'h3);
    chk("rr 3 pc", pc_out, 32'h400);
    runSlice(42, 32'h400, 1'b0);
    doDispatch(32'h68);
    chk("rr 0", 32'(cur_pid), 32'h0);
    chk("rr 0 pc", pc_out, 32'h2A8);
    runSlice(42, 32'h800, 1'b0);
    doDispatch(32'h6C);
    chk("rr 2 again", 32'(cur_pid), 32'h2);
    chk("rr 2 resume", pc_out, 32'h3A8);
    end_process = 1'b1; next_addr = 32'h3AC;
    tick();
    doDispatch(32'h70);
    chk("rr 3 again", 32'(cur_pid), 32'h3);
    end_process = 1'b1; next_addr = 32'h4AC;
    tick();
    doDispatch(32'h74);
    chk("rr 0 again", 32'(cur_pid), 32'h0);
    chk("rr 0 resume", pc_out, 32'h8A8);
    runSlice(42, 32'hA00, 1'b0);
    doDispatch(32'h78);
    chk("self reselect", 32'(cur_pid), 32'h0);
    chk("self reselect mode", 32'(os_mode), 32'h0);
    chk("self reselect pc", pc_out, 32'hAA8);

    // end_process on the quantum-expiry cycle.
    rd_pid = 2'd0;
    runSlice(41, 32'hB00, 1'b0);
    end_process = 1'b1; next_addr = 32'hC00;
    tick();
    chk("end+expiry active", 32'(active), 32'h0);
    chk("end+expiry rd_pc", rd_pc, 32'hAA8);
    chk("end+expiry ctx", 32'(ctx_switch), 32'h1);
    next_addr = 32'h7C;
    tick();
    chk("end+expiry single pulse", 32'(ctx_switch), 32'h0);

    // Stall mid-slice.
    rd_pid = 2'd1;
    next_addr = 32'h80; launch = 1'b1; launch_pid = 2'd1; launch_addr = 32'h500; dispatch = 1'b1;
    tick();
    chk("stall test dispatch", pc_out, 32'h500);
    runSlice(10, 32'h500, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      next_addr = 32'h900 + 32'(i);
      end_process = (i == 4);
      tick();
    end
    chk("stall frozen pc", pc_out, 32'h528);
    chk("stall frozen mode", 32'(os_mode), 32'h0);
    stall = 1'b0;
    runSlice(31, 32'h600, 1'b0);
    chk("stall no quantum use", 32'(os_mode), 32'h0);
    next_addr = 32'h700;
    tick();
    chk("stall expiry pc", pc_out, 32'h80);
    chk("stall expiry ctx", 32'(ctx_switch), 32'h1);
    stall = 1'b1;
    tick();
    chk("stall forces ctx 0", 32'(ctx_switch), 32'h0);
    stall = 1'b0;
    chk("stall saved pc", rd_pc, 32'h700);

    // Reset mid-slice.
    doDispatch(32'h88);
    chk("redispatch pc", pc_out, 32'h700);
    runSlice(5, 32'h700, 1'b0);
    #1 reset = 1'b1;
    modelReset();
    #1;
    chk("async reset pc", pc_out, 32'h0);
    chk("async reset active", 32'(active), 32'h0);
    chk("async reset mode", 32'(os_mode), 32'h1);
    chk("async reset rd_pc", rd_pc, 32'h0);
    tick();
    reset = 1'b0;
    next_addr = 32'h10;
    tick();
    chk("post reset follow", pc_out, 32'h10);
    @(negedge CLK);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule

// File: doc/pc_context_scheduler.md
Name: pc_context_scheduler

Overview:
- Parametrised program-counter block with a built-in preemptive round-robin scheduler for up to NPROC user processes.
- Normal sequencing: registers the next-address from the fetch/branch logic.
- Time-slice expiry or process end: saves the running process's resume PC and returns to the OS code.
- OS dispatch: restores the next ready process's PC.
- Sits between the next-PC mux and the instruction ROM address port. It is the successor of the single-context PC with a fixed instruction-count slice.

Parameters:
- ADDR_W, 32, PC and address width.
- NPROC, 4, number of process context slots (2..16).
- PID_W, 2, width of process id; must be at least clog2(NPROC).
- QUANTUM, 42, instructions per time slice (at least 2).
- RESET_ADDR, 0, PC value after reset (OS entry point).

Ports:
- CLK  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  I/O hold; while high, all state is frozen.
- next_addr  in  ADDR_W  next PC from the fetch/branch logic.
- end_process  in  1  running process executed its terminating instruction.
- launch  in  1  OS request to create a process in slot launch_pid.
- launch_pid  in  PID_W  slot to load.
- launch_addr  in  ADDR_W  start PC of the new process.
- dispatch  in  1  OS request to run the next ready process.
- rd_pid  in  PID_W  debug read select.
- pc_out  out  ADDR_W  current instruction address.
- os_mode  out  1  1 = OS code running, 0 = user process running.
- cur_pid  out  PID_W  id of the running or last-run process.
- ctx_switch  out  1  one-cycle pulse on a return to the OS.
- active  out  NPROC  per-slot "process alive" mask.
- rd_pc  out  ADDR_W  saved PC of slot rd_pid (combinational read).

Behaviour:
- Reset (async):
  - pc_out=RESET_ADDR, os_mode=1, cur_pid=0, ctx_switch=0.
  - active=0, slice counter=0, os_return=RESET_ADDR.
  - Saved-PC array cleared to 0.
  - Reset asserted mid-slice abandons the slice; no context is saved.
- All updates occur on the rising CLK edge. With stall=1, nothing changes except ctx_switch, which is forced to 0.
- ctx_switch defaults to 0 every unstalled cycle. It is 1 only on the cycle after a RUN->OS transition.
- State OS (os_mode=1), unstalled:
  - pc_out<=next_addr.
  - If launch: saved[launch_pid]<=launch_addr and active[launch_pid]<=1. This overwrites the slot even if it is already active. launch_pid >= NPROC is ignored.
  - If dispatch: search slots cur_pid+1, cur_pid+2, … modulo NPROC, ending with cur_pid itself; the first active slot wins.
    - If a slot is found: os_return<=next_addr, pc_out<=saved[pid], cur_pid<=pid, slice counter<=0, enter RUN.
    - If none is active: dispatch is ignored and the block stays in OS with pc_out<=next_addr.
  - launch and dispatch in the same cycle: the launch is applied first, so the freshly launched slot is eligible for that dispatch.
- State RUN (os_mode=0), unstalled:
  - Normally: pc_out<=next_addr, slice counter +1, and launch/dispatch are ignored.
  - If end_process: active[cur_pid]<=0, pc_out<=os_return, ctx_switch<=1, enter OS. The saved PC is left unchanged.
  - Else if slice counter==QUANTUM-1 (the QUANTUM-th instruction is in flight): saved[cur_pid]<=next_addr, pc_out<=os_return, ctx_switch<=1, enter OS.
  - end_process has priority over quantum expiry when both occur in the same cycle.
- Slice counter:
  - clog2(QUANTUM+1) bits wide; it never wraps.
  - Reset to 0 on every dispatch and held during stall.
  - Stalled cycles do not consume quantum.
- Wrap-around: PC arithmetic is external; next_addr is registered as given, and a wrap from all-ones to 0 is passed through unmodified.

Test Plan:
- Reset then 5 unstalled cycles with next_addr=4,8,12,16,20 -> pc_out follows one cycle later; os_mode=1; active=0; ctx_switch never pulses.
- launch pid1 @0x100, then dispatch with next_addr=0x40 -> pc_out=0x100, os_mode=0, cur_pid=1. After QUANTUM=42 unstalled cycles: pc_out=0x40, ctx_switch=1 for exactly 1 cycle, rd_pc(1)=the 42nd next_addr.
- Slots 0, 2, 3 active, cur_pid=0 -> successive dispatches select 2, 3, 0, 2; with only slot 0 active, dispatch reselects 0; with active=0, dispatch is ignored.
- end_process and quantum expiry in the same cycle -> active bit cleared, rd_pc unchanged, single ctx_switch pulse.
- stall held 10 cycles mid-slice -> pc_out and counter frozen, and the switch occurs 42 unstalled cycles after dispatch. reset asserted mid-slice -> pc_out=0 immediately and active=0.
